// File: rtl/spi_fifo_ctrl.sv
// Four-channel round-robin sample collector feeding a circular 16-bit FIFO read by an SPI slave.
// The output stage holds each popped word for one full cycle so the slave can latch it late.
module spi_fifo_ctrl #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [3:0]    req_valid,
    input  logic [63:0]   req_data,
    output logic [3:0]    req_ack,
    input  logic          flag_rd_fifo,
    output logic [15:0]   fifo_data,
    output logic          fifo_valid,
    output logic [AW:0]   fifo_count,
    output logic          ovf_flag,
    output logic          unf_flag,
    input  logic          clr_err
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_SHOW  = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    pp_q, pp_d;
    state_e        state_q, state_d;
    logic [15:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;

    logic          full_s, empty_s, push_s, pop_s;
    logic [3:0]    ack_s;
    logic [1:0]    gnt_idx_s;
    logic [15:0]   wdata_s;

    // Lowest rotation offset from ptr wins: scanning high-to-low lets the last hit stand.
    function automatic logic [3:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [3:0] gnt;
        logic [1:0] idx;
        gnt = 4'b0000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                gnt = 4'b0001 << idx;
            end else begin
                gnt = gnt;
            end
        end
        return gnt;
    endfunction

    assign full_s  = (count_q == DEPTH_C);
    assign empty_s = (count_q == {(AW+1){1'b0}});

    // Grant selection: no grant while full or in reset.
    always_comb begin
        ack_s = 4'b0000;
        if (!sys_rst && !full_s) begin
            ack_s = rr_pick(req_valid, pp_q);
        end else begin
            ack_s = 4'b0000;
        end
        case (ack_s)
            4'b0001: gnt_idx_s = 2'd0;
            4'b0010: gnt_idx_s = 2'd1;
            4'b0100: gnt_idx_s = 2'd2;
            4'b1000: gnt_idx_s = 2'd3;
            default: gnt_idx_s = 2'd0;
        endcase
    end

    assign push_s  = |ack_s;
    assign pop_s   = flag_rd_fifo && !empty_s;
    assign wdata_s = req_data[{gnt_idx_s, 4'b0000} +: 16];
    assign req_ack = ack_s;

    // Buffer storage; contents survive reset, only the pointers are cleared.
    always_ff @(posedge sys_clk) begin
        if (push_s) begin
            mem_q[wp_q] <= wdata_s;
        end
    end

    // Pointer, occupancy, arbiter pointer and sticky error next-state.
    always_comb begin
        wp_d = push_s ? (wp_q + AW'(1)) : wp_q;
        rp_d = pop_s  ? (rp_q + AW'(1)) : rp_q;
        pp_d = push_s ? (gnt_idx_s + 2'd1) : pp_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        if (full_s && (|req_valid)) begin
            ovf_d = 1'b1;
        end else if (clr_err) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (flag_rd_fifo && empty_s) begin
            unf_d = 1'b1;
        end else if (clr_err) begin
            unf_d = 1'b0;
        end else begin
            unf_d = unf_q;
        end
    end

    // Output FSM: any accepted pop freezes the popped word for the following cycle.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            ST_EMPTY, ST_SHOW, ST_HOLD: begin
                if (pop_s) begin
                    state_d = ST_HOLD;
                    data_d  = mem_q[rp_q];
                end else if (!empty_s) begin
                    state_d = ST_SHOW;
                    data_d  = mem_q[rp_q];
                end else begin
                    state_d = ST_EMPTY;
                    data_d  = 16'h0000;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                data_d  = 16'h0000;
            end
        endcase
        valid_d = (state_d != ST_EMPTY);
    end

    // State registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wp_q    <= {AW{1'b0}};
            rp_q    <= {AW{1'b0}};
            count_q <= {(AW+1){1'b0}};
            pp_q    <= 2'd0;
            state_q <= ST_EMPTY;
            data_q  <= 16'h0000;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            pp_q    <= pp_d;
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign fifo_data  = data_q;
    assign fifo_valid = valid_q;
    assign fifo_count = count_q;
    assign ovf_flag   = ovf_q;
    assign unf_flag   = unf_q;

endmodule

// File: tb/tb_spi_fifo_ctrl.sv
// Scoreboard bench for spi_fifo_ctrl: a queue-based reference model predicts grants and
// outputs per edge; a negedge monitor pops and compares them against the DUT.
module tb_spi_fifo_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          sys_clk;
    logic          sys_rst;
    logic [3:0]    req_valid;
    logic [63:0]   req_data;
    logic [3:0]    req_ack;
    logic          flag_rd_fifo;
    logic [15:0]   fifo_data;
    logic          fifo_valid;
    logic [AW:0]   fifo_count;
    logic          ovf_flag;
    logic          unf_flag;
    logic          clr_err;

    spi_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ack      (req_ack),
        .flag_rd_fifo (flag_rd_fifo),
        .fifo_data    (fifo_data),
        .fifo_valid   (fifo_valid),
        .fifo_count   (fifo_count),
        .ovf_flag     (ovf_flag),
        .unf_flag     (unf_flag),
        .clr_err      (clr_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [15:0] data;
        logic        valid;
        logic [AW:0] count;
        logic        ovf;
        logic        unf;
    } out_t;

    out_t        out_q[$];
    logic [3:0]  ack_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    // Reference model state: the buffer is simply a queue of words.
    logic [15:0] mq[$];
    int          m_pp = 0;
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    int          last_gnt = -1;

    function automatic int pick(input logic [3:0] v, input int pp, input bit full);
        if (full) return -1;
        for (int k = 0; k < 4; k++) begin
            if (v[(pp + k) % 4]) return (pp + k) % 4;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare whatever expectations are pending against the DUT.
    always @(negedge sys_clk) begin
        logic [3:0] ea;
        out_t       eo;
        if (ack_q.size() > 0) begin
            ea = ack_q.pop_front();
            chk("req_ack", {28'd0, req_ack}, {28'd0, ea});
        end
        if (out_q.size() > 0) begin
            eo = out_q.pop_front();
            chk("fifo_data",  {16'd0, fifo_data}, {16'd0, eo.data});
            chk("fifo_valid", {31'd0, fifo_valid}, {31'd0, eo.valid});
            chk("fifo_count", {27'd0, fifo_count}, {27'd0, eo.count});
            chk("ovf_flag",   {31'd0, ovf_flag}, {31'd0, eo.ovf});
            chk("unf_flag",   {31'd0, unf_flag}, {31'd0, eo.unf});
        end
    end

    task automatic drive(input logic rst, input logic [3:0] v, input logic [63:0] d,
                         input logic rd, input logic clr);
        int g;
        sys_rst      = rst;
        req_valid    = v;
        req_data     = d;
        flag_rd_fifo = rd;
        clr_err      = clr;
        g = pick(v, m_pp, mq.size() == DEPTH);
        if (rst || g < 0) ack_q.push_back(4'b0000);
        else              ack_q.push_back(4'b0001 << g);
    endtask

    // Apply the clock edge to the model using the inputs currently driven.
    task automatic step();
        int          pre;
        int          g;
        logic [15:0] w;
        bit          popped;
        out_t        o;
        @(posedge sys_clk);
        #1;
        if (sys_rst) begin
            mq.delete();
            m_pp = 0; m_ovf = 1'b0; m_unf = 1'b0; last_gnt = -1;
            o.data = 16'h0000; o.valid = 1'b0;
        end else begin
            pre = mq.size();
            g = pick(req_valid, m_pp, pre == DEPTH);
            popped = 1'b0;
            w = 16'h0000;
            if (flag_rd_fifo && pre > 0) begin
                w = mq.pop_front();
                popped = 1'b1;
            end
            if (g >= 0) begin
                mq.push_back(req_data[16*g +: 16]);
                m_pp = (g + 1) % 4;
            end
            if (pre == DEPTH && (|req_valid)) m_ovf = 1'b1;
            else if (clr_err)                 m_ovf = 1'b0;
            if (flag_rd_fifo && pre == 0)     m_unf = 1'b1;
            else if (clr_err)                 m_unf = 1'b0;
            if (popped) begin
                o.data = w; o.valid = 1'b1;
            end else if (pre > 0) begin
                o.data = mq[0]; o.valid = 1'b1;
            end else begin
                o.data = 16'h0000; o.valid = 1'b0;
            end
            last_gnt = g;
        end
        o.count = (AW+1)'(mq.size());
        o.ovf   = m_ovf;
        o.unf   = m_unf;
        out_q.push_back(o);
    endtask

    task automatic cyc(input logic rst, input logic [3:0] v, input logic [63:0] d,
                       input logic rd, input logic clr);
        drive(rst, v, d, rd, clr);
        step();
    endtask

    // Random cycle that honours hold-until-acknowledged on every channel.
    task automatic rand_cycle(input int p_req, input int p_rd, input int p_clr, input int p_rst);
        logic [3:0]  v;
        logic [63:0] d;
        v = req_valid;
        d = req_data;
        if (last_gnt >= 0) v[last_gnt] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i] && $urandom_range(99) < p_req) begin
                v[i] = 1'b1;
                d[16*i +: 16] = 16'($urandom);
            end
        end
        cyc($urandom_range(999) < p_rst, v, d, $urandom_range(99) < p_rd,
            $urandom_range(99) < p_clr);
    endtask

    initial begin
        sys_rst = 1'b1; req_valid = 4'b0000; req_data = 64'd0;
        flag_rd_fifo = 1'b0; clr_err = 1'b0;
        @(posedge sys_clk);
        #1;
        repeat (2) cyc(1'b1, 4'b0000, 64'd0, 1'b0, 1'b0);

        // Single sample on channel 2, then pop it, then pop an empty buffer and clear.
        cyc(1'b0, 4'b0100, 64'h0000_A5C3_0000_0000, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 4'b0000, 64'd0, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 64'd0, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 4'b0000, 64'd0, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 64'd0, 1'b1, 1'b0);
        cyc(1'b0, 4'b0000, 64'd0, 1'b0, 1'b1);
        cyc(1'b0, 4'b0000, 64'd0, 1'b0, 1'b0);

        // All channels requesting until full, then pop and request together while full.
        cyc(1'b1, 4'b0000, 64'd0, 1'b0, 1'b0);
        repeat (20) cyc(1'b0, 4'b1111, 64'h1003_1002_1001_1000, 1'b0, 1'b0);
        cyc(1'b0, 4'b1111, 64'h1003_1002_1001_1000, 1'b1, 1'b0);
        cyc(1'b0, 4'b0000, 64'd0, 1'b0, 1'b1);
        cyc(1'b0, 4'b0001, 64'h0000_0000_0000_BEEF, 1'b0, 1'b0);
        repeat (17) cyc(1'b0, 4'b0000, 64'd0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 4'b0010, {32'd0, 16'(16'h5A00 + i), 16'd0}, 1'b0, 1'b0);
        repeat (17) cyc(1'b0, 4'b0000, 64'd0, 1'b1, 1'b0);

        // Reset with five words buffered, then a fresh push must be the first word out.
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'b1000, {16'(16'h7700 + i), 48'd0}, 1'b0, 1'b0);
        cyc(1'b1, 4'b0000, 64'd0, 1'b0, 1'b0);
        cyc(1'b0, 4'b0001, 64'h0000_0000_0000_C0DE, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 4'b0000, 64'd0, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 64'd0, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 4'b0000, 64'd0, 1'b0, 1'b0);

        // Randomised traffic with drain rates ranging from rarely-empty to mostly-empty.
        for (int ph = 0; ph < 3; ph++) begin
            for (int n = 0; n < 1000; n++) begin
                rand_cycle(30 + 10 * ph, 15 + 35 * ph, 5, 3);
            end
        end
        repeat (3) cyc(1'b0, 4'b0000, 64'd0, 1'b0, 1'b0);

        repeat (2) @(negedge sys_clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
